// File: rtl/clock_enable_divider.sv
// Multi-channel clock-enable generator. Each channel divides the system clock
// by a runtime-programmable ratio R = divisor + 1. It emits a one-cycle tick
// per period and a registered near-50% square wave. New divisors are staged
// and take effect only at a period boundary, or at once on sync, so that no
// period is ever truncated or stretched.
module clock_enable_divider #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16,
  parameter int RESET_DIV = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          sync,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   divisor,
  output logic [NUM_CH-1:0]             tick_out,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             pending_out
);

  localparam logic [DIV_WIDTH-1:0] RESET_DIV_W = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH:0]   ONE_W1      = (DIV_WIDTH+1)'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] count_reg, count_next;
      logic [DIV_WIDTH-1:0] div_active_reg, div_active_next;
      logic [DIV_WIDTH-1:0] div_pending_reg, div_pending_next;
      logic                 pending_valid_reg, pending_valid_next;
      logic                 tick_reg, tick_next;
      logic                 clk_reg, clk_next;
      logic [DIV_WIDTH-1:0] load_val;
      logic [DIV_WIDTH:0]   half_next;
      logic                 terminal;

      assign load_val = divisor[gi*DIV_WIDTH +: DIV_WIDTH];
      // count never passes div_active, so equality is the period boundary
      assign terminal = (count_reg == div_active_reg);

      // Next-state: sync realigns, otherwise load staging and run-gated counting
      always_comb begin
        count_next         = count_reg;
        div_active_next    = div_active_reg;
        div_pending_next   = div_pending_reg;
        pending_valid_next = pending_valid_reg;
        tick_next          = 1'b0;
        clk_next           = clk_reg;
        half_next          = '0;

        if (sync) begin
          count_next         = '0;
          clk_next           = 1'b0;
          pending_valid_next = 1'b0;
          if (load[gi]) begin
            // a load coinciding with sync is applied straight away
            div_active_next  = load_val;
            div_pending_next = load_val;
          end else if (pending_valid_reg) begin
            div_active_next = div_pending_reg;
          end
        end else begin
          if (load[gi]) begin
            div_pending_next   = load_val;
            pending_valid_next = 1'b1;
          end
          if (run) begin
            if (terminal) begin
              count_next = '0;
              tick_next  = 1'b1;
              // the new ratio governs the period that starts at count 0
              if (load[gi]) begin
                div_active_next    = load_val;
                pending_valid_next = 1'b0;
              end else if (pending_valid_reg) begin
                div_active_next    = div_pending_reg;
                pending_valid_next = 1'b0;
              end
            end else begin
              count_next = count_reg + DIV_WIDTH'(1);
            end
            // H = floor(R/2), widened by one bit so R = 2^DIV_WIDTH fits
            half_next = ({1'b0, div_active_next} + ONE_W1) >> 1;
            clk_next  = ({1'b0, count_next} >= half_next);
          end
        end
      end

      // State register with synchronous reset to the default ratio
      always_ff @(posedge clock) begin
        if (reset) begin
          count_reg         <= '0;
          div_active_reg    <= RESET_DIV_W;
          div_pending_reg   <= RESET_DIV_W;
          pending_valid_reg <= 1'b0;
          tick_reg          <= 1'b0;
          clk_reg           <= 1'b0;
        end else begin
          count_reg         <= count_next;
          div_active_reg    <= div_active_next;
          div_pending_reg   <= div_pending_next;
          pending_valid_reg <= pending_valid_next;
          tick_reg          <= tick_next;
          clk_reg           <= clk_next;
        end
      end

      assign tick_out[gi]    = tick_reg;
      assign clk_out[gi]     = clk_reg;
      assign pending_out[gi] = pending_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clock_enable_divider.sv
// Bench for clock_enable_divider. Expected outputs come from a period/phase
// model, pushed to a queue when each cycle's stimulus is driven and popped
// after the edge. Scenario tasks also check fixed timing facts directly.
module tb_clock_enable_divider;
  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              run   = 1'b0;
  logic              sync  = 1'b0;
  logic [NCH-1:0]    load  = '0;
  logic [NCH*DW-1:0] divisor = '0;
  logic [NCH-1:0]    tick_out, clk_out, pending_out;

  clock_enable_divider #(.NUM_CH(NCH), .DIV_WIDTH(DW), .RESET_DIV(5)) dut (
    .clock(clock), .reset(reset), .run(run), .sync(sync), .load(load),
    .divisor(divisor), .tick_out(tick_out), .clk_out(clk_out),
    .pending_out(pending_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk;
    logic [NCH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  // model state: phase, period, pending period, pending flag, outputs
  int m_p[NCH], m_r[NCH], m_pr[NCH];
  bit m_pv[NCH], m_tick[NCH], m_clk[NCH];

  // Drive one cycle of stimulus, advance the model, queue the expectation.
  task automatic cycle(input logic rst, input logic r, input logic s,
                       input logic [NCH-1:0] ld, input logic [NCH*DW-1:0] dv);
    exp_t x;
    int f;
    @(negedge clock);
    reset = rst; run = r; sync = s; load = ld; divisor = dv;
    for (int c = 0; c < NCH; c++) begin
      f = int'(dv[c*DW +: DW]) + 1;
      if (rst) begin
        m_p[c] = 0; m_r[c] = 6; m_pv[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
      end else if (s) begin
        if (ld[c]) m_r[c] = f;
        else if (m_pv[c]) m_r[c] = m_pr[c];
        m_p[c] = 0; m_pv[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
      end else begin
        if (ld[c]) begin m_pr[c] = f; m_pv[c] = 1; end
        if (r) begin
          if (m_p[c] == m_r[c] - 1) begin
            m_p[c] = 0; m_tick[c] = 1;
            if (m_pv[c]) begin m_r[c] = m_pr[c]; m_pv[c] = 0; end
          end else begin
            m_p[c] = m_p[c] + 1; m_tick[c] = 0;
          end
          m_clk[c] = (m_p[c] >= m_r[c] / 2);
        end else begin
          m_tick[c] = 0;
        end
      end
      x.tick[c] = m_tick[c]; x.clk[c] = m_clk[c]; x.pend[c] = m_pv[c];
    end
    exp_q.push_back(x);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    $display("tb: test_reset");
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL reset_model got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
      end
    end
    checks++;
    if ({tick_out, clk_out, pending_out} !== 12'h000) begin
      failures++;
      $display("FAIL reset_zero got=%h exp=000", {tick_out, clk_out, pending_out});
    end
  endtask

  task automatic test_default_rate();
    int first_tick = -1;
    int clk_high = 0;
    $display("tb: test_default_rate");
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL default_model cyc=%0d got=%h exp=%h", i, {tick_out, clk_out, pending_out}, e);
      end
      if (tick_out[0] && first_tick < 0) first_tick = i;
      if (i <= 6 && clk_out[0]) clk_high++;
    end
    checks++;
    if (first_tick != 6) begin
      failures++;
      $display("FAIL default_first_tick got=%0d exp=6", first_tick);
    end
    checks++;
    if (clk_high != 3) begin
      failures++;
      $display("FAIL default_clk_high got=%0d exp=3", clk_high);
    end
  endtask

  task automatic test_reload();
    int last = -1;
    $display("tb: test_reload ch1 div=2");
    cycle(1'b0, 1'b1, 1'b0, '0, '0);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
      failures++;
      $display("FAIL reload_pre got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b0010, 64'h0000_0000_0002_0000);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
      failures++;
      $display("FAIL reload_load got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
    end
    checks++;
    if (pending_out[1] !== 1'b1) begin
      failures++;
      $display("FAIL reload_pending got=%b exp=1", pending_out[1]);
    end
    for (int k = 1; k <= 14; k++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL reload_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
      if (tick_out[1]) begin
        checks++;
        if ((last < 0 && k != 2) || (last >= 0 && k - last != 3)) begin
          failures++;
          $display("FAIL reload_tick_spacing k=%0d prev=%0d exp_first=2 exp_gap=3", k, last);
        end
        last = k;
      end
      if (k == 2) begin
        checks++;
        if (pending_out[1] !== 1'b0) begin
          failures++;
          $display("FAIL reload_pending_clear got=%b exp=0", pending_out[1]);
        end
      end
    end
  endtask

  task automatic test_sync_r1();
    $display("tb: test_sync_r1 ch2 div=0 with sync");
    cycle(1'b0, 1'b1, 1'b1, 4'b0100, '0);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
      failures++;
      $display("FAIL sync_model got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
    end
    checks++;
    if ({tick_out, clk_out, pending_out} !== 12'h000) begin
      failures++;
      $display("FAIL sync_zero got=%h exp=000", {tick_out, clk_out, pending_out});
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL sync_run_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
      checks++;
      if ({tick_out[2], clk_out[2]} !== 2'b11) begin
        failures++;
        $display("FAIL r1_const k=%0d got=%b exp=11", k, {tick_out[2], clk_out[2]});
      end
    end
  endtask

  task automatic test_freeze();
    int n = 0;
    $display("tb: test_freeze run=0 for 10 cycles");
    while (m_p[0] != 4 && n < 12) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL freeze_align got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
      end
    end
    checks++;
    if (m_p[0] != 4) begin
      failures++;
      $display("FAIL freeze_reach_count4 got=%0d exp=4", m_p[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL freeze_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
      checks++;
      if (tick_out !== 4'b0000) begin
        failures++;
        $display("FAIL freeze_no_tick k=%0d got=%b exp=0000", k, tick_out);
      end
    end
    for (int k = 1; k <= 2; k++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL resume_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
      checks++;
      if (tick_out[0] !== (k == 2)) begin
        failures++;
        $display("FAIL resume_tick k=%0d got=%b exp=%b", k, tick_out[0], (k == 2));
      end
    end
  endtask

  task automatic test_terminal_load();
    int n;
    $display("tb: test_terminal_load ch3 div=9 then overwrite div=1");
    n = 0;
    while (m_p[3] != m_r[3] - 1 && n < 12) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL term_align got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 4'b1000, 64'h0009_0000_0000_0000);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
      failures++;
      $display("FAIL term_load got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
    end
    checks++;
    if ({tick_out[3], pending_out[3]} !== 2'b10) begin
      failures++;
      $display("FAIL term_load_apply got=%b exp=10", {tick_out[3], pending_out[3]});
    end
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL term_r10_model n=%0d got=%h exp=%h", n, {tick_out, clk_out, pending_out}, e);
      end
    end while (!tick_out[3] && n < 20);
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL term_period10 got=%0d exp=10", n);
    end
    // mid-period load then overwrite before the boundary: last value wins
    for (int k = 0; k < 5; k++) begin
      if (k == 3) begin
        cycle(1'b0, 1'b1, 1'b0, 4'b1000, 64'h0009_0000_0000_0000);
      end else if (k == 4) begin
        cycle(1'b0, 1'b1, 1'b0, 4'b1000, 64'h0001_0000_0000_0000);
      end else begin
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
      end
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL overwrite_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
    end
    checks++;
    if (pending_out[3] !== 1'b1) begin
      failures++;
      $display("FAIL overwrite_pending got=%b exp=1", pending_out[3]);
    end
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL overwrite_wait n=%0d got=%h exp=%h", n, {tick_out, clk_out, pending_out}, e);
      end
    end while (!tick_out[3] && n < 20);
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      n++;
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL overwrite_r2_model n=%0d got=%h exp=%h", n, {tick_out, clk_out, pending_out}, e);
      end
    end while (!tick_out[3] && n < 20);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL overwrite_period2 got=%0d exp=2", n);
    end
  endtask

  task automatic test_reset_mid();
    $display("tb: test_reset_mid");
    cycle(1'b0, 1'b1, 1'b0, 4'b0001, 64'h0000_0000_0000_0007);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
      failures++;
      $display("FAIL rstmid_load got=%h exp=%h", {tick_out, clk_out, pending_out}, e);
    end
    cycle(1'b1, 1'b1, 1'b0, '0, '0);
    e = exp_q.pop_front(); checks++;
    if ({tick_out, clk_out, pending_out} !== 12'h000) begin
      failures++;
      $display("FAIL rstmid_zero got=%h exp=000", {tick_out, clk_out, pending_out});
    end
    for (int k = 1; k <= 13; k++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, '0);
      e = exp_q.pop_front(); checks++;
      if ({tick_out, clk_out, pending_out} !== {e.tick, e.clk, e.pend}) begin
        failures++;
        $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, {tick_out, clk_out, pending_out}, e);
      end
      checks++;
      if (tick_out !== ((k % 6 == 0) ? 4'b1111 : 4'b0000)) begin
        failures++;
        $display("FAIL rstmid_r6 k=%0d got=%b exp=%b", k, tick_out, (k % 6 == 0) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_reload();
    test_sync_r1();
    test_freeze();
    test_terminal_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
